// File: rtl/gb_stream_pkg.sv
// Shared types and widths for the Gaussian-blur output stream path.
// Defines the packed output word carried between the packer and its word buffer.
package gb_stream_pkg;

  localparam int PIX_W  = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int CNT_W  = 20;
  localparam int IDX_W  = $clog2(LANES);

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [LANES-1:0]  keep;
    logic              last;
  } gb_word_t;

  // Lanes 0..last_lane are populated in a word closed at last_lane.
  function automatic logic [LANES-1:0] keep_mask(input logic [IDX_W-1:0] last_lane);
    keep_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_mask[i] = (IDX_W'(i) <= last_lane);
    end
  endfunction

endpackage

// File: rtl/gb_word_fifo.sv
// Small synchronous word buffer; entry 0 is always the head, so the outputs
// come straight from registers and stay put while the consumer stalls.
module gb_word_fifo
  import gb_stream_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     push,
  input  gb_word_t push_word,
  input  logic     pop,
  output gb_word_t head,
  output logic     valid,
  output logic     full
);

  localparam int CW = $clog2(DEPTH + 1);

  gb_word_t       mem   [DEPTH];
  gb_word_t       mem_n [DEPTH];
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_n;
  logic           do_push;
  logic           do_pop;
  int             wr_idx;

  // A pop shifts everything toward the head; a simultaneous push lands in
  // the slot just vacated at the tail so occupancy is unchanged.
  always_comb begin
    do_pop  = pop && (cnt != '0);
    do_push = push && !full;
    mem_n   = mem;
    wr_idx  = do_pop ? int'(cnt) - 1 : int'(cnt);
    if (do_pop) begin
      for (int i = 0; i < DEPTH - 1; i++) begin
        mem_n[i] = mem[i+1];
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (do_push && (i == wr_idx)) begin
        mem_n[i] = push_word;
      end
    end
    cnt_n = cnt;
    if (do_push && !do_pop) begin
      cnt_n = cnt + CW'(1);
    end else if (!do_push && do_pop) begin
      cnt_n = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
      cnt <= '0;
    end else begin
      mem <= mem_n;
      cnt <= cnt_n;
    end
  end

  assign head  = mem[0];
  assign valid = (cnt != '0);
  assign full  = (cnt == CW'(DEPTH));

endmodule

// File: rtl/gb_out_packer.sv
// Packs 8-bit blurred pixels into 32-bit AXI-stream words, closing words early
// at frame end and flagging frames whose TLAST disagrees with the configured length.
module gb_out_packer
  import gb_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PIX_W-1:0]     s_TDATA,
  input  logic                 s_TLAST,
  input  logic                 s_TVALID,
  output logic                 s_TREADY,
  output logic [WORD_W-1:0]    m_TDATA,
  output logic [LANES-1:0]     m_TKEEP,
  output logic                 m_TLAST,
  output logic                 m_TVALID,
  input  logic                 m_TREADY,
  input  logic [CNT_W-1:0]     cfg_frame_pixels,
  input  logic                 err_clr,
  output logic                 err_tlast_early,
  output logic                 err_tlast_missing,
  output logic                 frame_done
);

  logic                        rst_d;
  logic                        fifo_full;
  logic                        accept;
  logic [LANES-1:0][PIX_W-1:0] lanes;
  logic [IDX_W-1:0]            idx;
  logic [CNT_W-1:0]            pix_cnt;
  logic [CNT_W-1:0]            exp_len;
  logic [CNT_W-1:0]            eff_len;
  logic [CNT_W-1:0]            cnt_next;
  logic                        len_hit;
  logic                        frame_end;
  logic                        close_word;
  gb_word_t                    word;
  gb_word_t                    head;

  // Ready is held low through reset and the cycle that follows it.
  assign s_TREADY = ~rst & ~rst_d & ~fifo_full;
  assign accept   = s_TVALID & s_TREADY;

  // The first pixel of a frame sees the live cfg value; later pixels use the latched length.
  assign eff_len    = (pix_cnt == '0) ? cfg_frame_pixels : exp_len;
  assign cnt_next   = pix_cnt + CNT_W'(1);
  assign len_hit    = (eff_len != '0) && (cnt_next == eff_len);
  assign frame_end  = s_TLAST | len_hit;
  assign close_word = accept & ((idx == IDX_W'(LANES - 1)) | frame_end);

  always_comb begin
    word.data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (IDX_W'(i) < idx) begin
        word.data[i*PIX_W +: PIX_W] = lanes[i];
      end else if (IDX_W'(i) == idx) begin
        word.data[i*PIX_W +: PIX_W] = s_TDATA;
      end
    end
    word.keep = keep_mask(idx);
    word.last = frame_end;
  end

  always_ff @(posedge clk) begin
    rst_d <= rst;
    if (rst) begin
      lanes             <= '0;
      idx               <= '0;
      pix_cnt           <= '0;
      exp_len           <= '0;
      err_tlast_early   <= 1'b0;
      err_tlast_missing <= 1'b0;
      frame_done        <= 1'b0;
    end else begin
      frame_done        <= accept & frame_end;
      err_tlast_early   <= (err_tlast_early & ~err_clr) |
                           (accept & s_TLAST & (eff_len != '0) & (cnt_next < eff_len));
      err_tlast_missing <= (err_tlast_missing & ~err_clr) |
                           (accept & ~s_TLAST & len_hit);
      if (accept) begin
        if (pix_cnt == '0) begin
          exp_len <= cfg_frame_pixels;
        end
        pix_cnt <= frame_end ? '0 : cnt_next;
        if (close_word) begin
          lanes <= '0;
          idx   <= '0;
        end else begin
          lanes[idx] <= s_TDATA;
          idx        <= idx + IDX_W'(1);
        end
      end
    end
  end

  gb_word_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (close_word),
    .push_word(word),
    .pop      (m_TVALID & m_TREADY),
    .head     (head),
    .valid    (m_TVALID),
    .full     (fifo_full)
  );

  assign m_TDATA = head.data;
  assign m_TKEEP = head.keep;
  assign m_TLAST = head.last;

endmodule

// File: tb/tb_gb_out_packer.sv
// Scoreboard bench: a pixel-list reference model queues expected words on each
// accepted pixel, and a monitor pops and compares whenever the packer emits one.
module tb_gb_out_packer;

  localparam int FIFO_DEPTH = 2;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } exp_word_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_TDATA = '0;
  logic        s_TLAST = 1'b0;
  logic        s_TVALID = 1'b0;
  logic        s_TREADY;
  logic [31:0] m_TDATA;
  logic [3:0]  m_TKEEP;
  logic        m_TLAST;
  logic        m_TVALID;
  logic        m_TREADY = 1'b0;
  logic [19:0] cfg_frame_pixels = '0;
  logic        err_clr = 1'b0;
  logic        err_tlast_early;
  logic        err_tlast_missing;
  logic        frame_done;

  int          checks = 0;
  int          errors = 0;
  int          ready_mode = 1;
  logic [19:0] next_cfg = '0;
  bit          rand_clr = 0;

  exp_word_t   exp_q[$];
  logic [7:0]  pend[$];
  int          m_cnt = 0;
  int          m_exp = 0;
  bit          m_early = 0;
  bit          m_missing = 0;
  bit          exp_done = 0;

  bit          held_v = 0;
  exp_word_t   held;
  exp_word_t   got;

  gb_out_packer #(.FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .s_TDATA          (s_TDATA),
    .s_TLAST          (s_TLAST),
    .s_TVALID         (s_TVALID),
    .s_TREADY         (s_TREADY),
    .m_TDATA          (m_TDATA),
    .m_TKEEP          (m_TKEEP),
    .m_TLAST          (m_TLAST),
    .m_TVALID         (m_TVALID),
    .m_TREADY         (m_TREADY),
    .cfg_frame_pixels (cfg_frame_pixels),
    .err_clr          (err_clr),
    .err_tlast_early  (err_tlast_early),
    .err_tlast_missing(err_tlast_missing),
    .frame_done       (frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: pixels gather in a list and leave as a word once four are
  // held or the frame ends; frame length rules are applied per pixel position.
  task automatic modelCycle(input bit acc, input logic [7:0] d, input bit l,
                            input bit clr, input logic [19:0] cfg);
    bit early = 0;
    bit missing = 0;
    bit fend = 0;
    exp_word_t w;
    if (acc) begin
      if (m_cnt == 0) m_exp = int'(cfg);
      m_cnt++;
      pend.push_back(d);
      early   = l && (m_exp != 0) && (m_cnt < m_exp);
      missing = !l && (m_exp != 0) && (m_cnt == m_exp);
      fend    = l || ((m_exp != 0) && (m_cnt == m_exp));
      if (pend.size() == 4 || fend) begin
        w.data = '0;
        for (int k = 0; k < pend.size(); k++) w.data[8*k +: 8] = pend[k];
        w.keep = 4'((1 << pend.size()) - 1);
        w.last = fend;
        exp_q.push_back(w);
        pend.delete();
      end
      if (fend) m_cnt = 0;
    end
    m_early   = (m_early && !clr) || early;
    m_missing = (m_missing && !clr) || missing;
    exp_done  = acc && fend;
  endtask

  task automatic applyStimulus(input bit v, input logic [7:0] d, input bit l,
                               input bit clr, output bit acc);
    logic [19:0] cfg;
    @(negedge clk);
    if (!rst) begin
      checkOutput("frame_done", frame_done, exp_done);
      checkOutput("err_tlast_early", err_tlast_early, m_early);
      checkOutput("err_tlast_missing", err_tlast_missing, m_missing);
    end
    cfg_frame_pixels = next_cfg;
    s_TVALID = v;
    s_TDATA  = d;
    s_TLAST  = l;
    err_clr  = clr;
    #4;
    acc = v && (s_TREADY === 1'b1);
    cfg = cfg_frame_pixels;
    @(posedge clk);
    modelCycle(acc, d, l, clr, cfg);
  endtask

  task automatic idle(input int n, input bit clr);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(0, 8'h00, 0, clr, acc);
  endtask

  task automatic sendPixel(input logic [7:0] d, input bit l, input bit gaps);
    bit acc = 0;
    int tries = 0;
    while (!acc && tries < 200) begin
      if (gaps && $urandom_range(0, 3) == 0) idle(1, 0);
      applyStimulus(1, d, l, rand_clr && ($urandom_range(0, 15) == 0), acc);
      tries++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL accept_timeout: pixel 0x%0h not accepted in %0d cycles", d, tries);
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    rst = 1'b1;
    s_TVALID = 1'b0;
    err_clr = 1'b0;
    exp_q.delete();
    pend.delete();
    m_cnt = 0;
    m_early = 0;
    m_missing = 0;
    exp_done = 0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_s_TREADY", s_TREADY, 0);
    checkOutput("rst_m_TVALID", m_TVALID, 0);
    checkOutput("rst_m_TDATA", m_TDATA, 0);
    checkOutput("rst_m_TKEEP", m_TKEEP, 0);
    checkOutput("rst_m_TLAST", m_TLAST, 0);
    checkOutput("rst_err_early", err_tlast_early, 0);
    checkOutput("rst_err_missing", err_tlast_missing, 0);
    checkOutput("rst_frame_done", frame_done, 0);
    rst = 1'b0;
  endtask

  // Output ready pattern: random, forced high, or forced low.
  initial begin
    forever begin
      @(negedge clk);
      case (ready_mode)
        0:       m_TREADY = ($urandom_range(0, 3) != 0);
        1:       m_TREADY = 1'b1;
        default: m_TREADY = 1'b0;
      endcase
    end
  end

  // Monitor: compares each emitted word against the scoreboard head and
  // checks that a stalled word holds still.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (rst) begin
        held_v = 0;
      end else begin
        if (held_v) begin
          checkOutput("hold_valid", m_TVALID, 1);
          checkOutput("hold_data", m_TDATA, held.data);
          checkOutput("hold_keep", m_TKEEP, held.keep);
          checkOutput("hold_last", m_TLAST, held.last);
        end
        if (m_TVALID && m_TREADY) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_word: got data 0x%0h keep 0x%0h last %0d, expected none",
                     m_TDATA, m_TKEEP, m_TLAST);
          end else begin
            got = exp_q.pop_front();
            checkOutput("word_data", m_TDATA, got.data);
            checkOutput("word_keep", m_TKEEP, got.keep);
            checkOutput("word_last", m_TLAST, got.last);
          end
          held_v = 0;
        end else if (m_TVALID) begin
          held_v = 1;
          held.data = m_TDATA;
          held.keep = m_TKEEP;
          held.last = m_TLAST;
        end else begin
          held_v = 0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit acc;
    int sent;
    int n;
    logic [19:0] cfg_choices [6];
    cfg_choices[0] = 20'd0; cfg_choices[1] = 20'd3; cfg_choices[2] = 20'd4;
    cfg_choices[3] = 20'd5; cfg_choices[4] = 20'd7; cfg_choices[5] = 20'd9;

    ready_mode = 1;
    doReset();

    $display("[TB] full frame, length matches");
    next_cfg = 20'd8;
    for (int i = 1; i <= 8; i++) sendPixel(8'(i), i == 8, 0);
    idle(3, 0);

    $display("[TB] frame ending on a partial word");
    next_cfg = 20'd6;
    for (int i = 1; i <= 6; i++) sendPixel(8'(8'h10 + i), i == 6, 0);
    idle(3, 0);

    $display("[TB] early TLAST");
    next_cfg = 20'd8;
    for (int i = 1; i <= 5; i++) sendPixel(8'(i), i == 5, 0);
    idle(3, 0);
    idle(1, 1);
    idle(2, 0);

    $display("[TB] missing TLAST");
    next_cfg = 20'd4;
    for (int i = 1; i <= 4; i++) sendPixel(8'(8'h40 + i), 0, 0);
    idle(2, 0);
    idle(1, 1);
    idle(2, 0);

    $display("[TB] backpressure stall");
    next_cfg = 20'd16;
    ready_mode = 2;
    sent = 0;
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1, 8'(8'h30 + sent), sent == 15, 0, acc);
      if (acc) sent++;
    end
    checkOutput("stall_accepted", sent, FIFO_DEPTH * 4);
    checkOutput("stall_s_TREADY", s_TREADY, 0);
    ready_mode = 1;
    while (sent < 16) begin
      sendPixel(8'(8'h30 + sent), sent == 15, 0);
      sent++;
    end
    idle(4, 0);

    $display("[TB] reset mid-frame");
    next_cfg = 20'd8;
    for (int i = 1; i <= 3; i++) sendPixel(8'(8'h50 + i), 0, 0);
    doReset();
    next_cfg = 20'd0;
    for (int i = 1; i <= 4; i++) sendPixel(8'(8'h20 + i), i == 4, 0);
    idle(3, 0);

    $display("[TB] randomized traffic");
    ready_mode = 0;
    rand_clr = 1;
    for (int p = 0; p < 400; p++) begin
      if ($urandom_range(0, 5) == 0) next_cfg = cfg_choices[$urandom_range(0, 5)];
      sendPixel(8'($urandom), $urandom_range(0, 9) == 0, 1);
    end
    rand_clr = 0;

    ready_mode = 1;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      idle(1, 0);
      n++;
    end
    idle(2, 0);
    checkOutput("drain_queue_empty", exp_q.size(), 0);
    checkOutput("drain_m_TVALID", m_TVALID, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
